multicycle_controller: RTL and testbench

- Sequencing FSM for the multi-cycle RV32I datapath. It uses one shared ALU and one unified instruction/data memory port.
- It steps each instruction through fetch, decode, execute, memory and writeback, and drives all datapath mux selects and write enables.
- It handles a ready-based memory handshake with an optional timeout, counts retired instructions, and traps on illegal opcodes.

---
 rtl/multicycle_controller.sv | 243 ++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Sequencing FSM for a multi-cycle RV32I datapath with a shared ALU and a unified memory port
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 0,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 MemWrite,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic                 PCUpdate,
  output logic                 Branch,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOp,
  output logic [2:0]           ImmSrc,
  output logic                 instr_done,
  output logic [INSTRET_W-1:0] instret,
  output logic                 fault,
  output logic [1:0]           fault_cause,
  output logic [3:0]           state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_FAULT    = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] TIMEOUT = 32'(MEM_TIMEOUT);

  state_t                 state_q, state_d;
  logic [31:0]            wait_q, wait_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;
  logic                   fault_q, fault_d;
  logic [1:0]             cause_q, cause_d;
  logic                   mem_access;
  logic                   timeout_hit;

  // Ungated view of the request, so the timeout still sees accesses while reset is asserted.
  assign mem_access  = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  assign timeout_hit = (MEM_TIMEOUT != 0) && mem_access && !mem_ready
                       && ((wait_q + 32'd1) >= TIMEOUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
      fault_q   <= 1'b0;
      cause_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      fault_q   <= fault_d;
      cause_q   <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    fault_d = fault_q;
    unique case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_IMM:            state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default: begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            cause_d = 2'b01;
          end
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_LUI, S_AUIPC: state_d = S_ALUWB;
      S_ALUWB, S_BRANCH: state_d = S_FETCH;
      S_JALR:     state_d = S_JAL;
      default:    state_d = S_FAULT;
    endcase
    if (timeout_hit) begin
      state_d = S_FAULT;
      fault_d = 1'b1;
      cause_d = 2'b10;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (mem_access && !mem_ready) begin
      wait_d = wait_q + 32'd1;
    end
    instret_d = instr_done ? instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1} : instret_q;
  end

  always_comb begin
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCUpdate   = 1'b0;
    Branch     = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    instr_done = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCUpdate  = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR, S_JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req    = 1'b1;
        MemWrite   = 1'b1;
        AdrSrc     = 1'b1;
        instr_done = mem_ready;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = (funct3 == 3'b000) ? 2'b00 : 2'b10;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        Branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        PCUpdate = 1'b1;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
      end
      S_AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      default: ;
    endcase
    // Reset must kill any in-flight access or writeback in the very cycle it is seen.
    if (rst) begin
      mem_req    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      PCUpdate   = 1'b0;
      Branch     = 1'b0;
      RegWrite   = 1'b0;
      instr_done = 1'b0;
    end
  end

  always_comb begin
    unique case (opcode)
      OP_STORE:        ImmSrc = 3'b001;
      OP_BRANCH:       ImmSrc = 3'b010;
      OP_JAL:          ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
      default:         ImmSrc = 3'b000;
    endcase
  end

  assign instret     = instret_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - Table-driven and directed checks for multicycle_controller
module tb_multicycle_controller;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] AUIP = 7'b0010111;
  localparam logic [6:0] BAD  = 7'b0000000;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       mem_ready;
  logic       mem_req, MemWrite, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;
  logic       instr_done;
  logic [2:0] instret;
  logic       fault;
  logic [1:0] fault_cause;
  logic [3:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(4), .INSTRET_W(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCUpdate(PCUpdate), .Branch(Branch), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
    .instr_done(instr_done), .instret(instret), .fault(fault),
    .fault_cause(fault_cause), .state_o(state_o)
  );

  // en = {mem_req, MemWrite, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite}
  typedef struct {
    logic       r;
    logic [6:0] op;
    logic [2:0] f3;
    logic       rdy;
    logic [3:0] st;
    logic [6:0] en;
    logic [1:0] rs, sa, sb, aop;
    logic       done, flt;
    logic [1:0] cause;
    logic [2:0] ir;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic r, input logic [6:0] op, input logic [2:0] f3,
                             input logic rdy, input logic [3:0] st, input logic [6:0] en,
                             input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                             input logic [1:0] aop, input logic done, input logic flt,
                             input logic [1:0] cause, input logic [2:0] ir);
    vec_t t;
    t.r = r; t.op = op; t.f3 = f3; t.rdy = rdy; t.st = st; t.en = en;
    t.rs = rs; t.sa = sa; t.sb = sb; t.aop = aop; t.done = done; t.flt = flt;
    t.cause = cause; t.ir = ir;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [6:0] op, input logic [2:0] f3, input logic rdy);
    @(posedge clk);
    #1;
    rst = r; opcode = op; funct3 = f3; mem_ready = rdy;
    @(negedge clk);
  endtask

  logic [31:0] act_w, exp_w;

  initial begin
    rst = 1'b1; opcode = ADD; funct3 = 3'b000; mem_ready = 1'b1;
    repeat (2) @(posedge clk);

    //               r  op    f3 rdy st    en          rs sa sb aop d f cause ir
    vecs.push_back(v(1, ADD,  0, 1, 4'd0,  7'b0000000, 2, 0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, ADD,  0, 1, 4'd0,  7'b1001100, 2, 0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, ADD,  0, 1, 4'd1,  7'b0000000, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, ADD,  0, 1, 4'd6,  7'b0000000, 0, 2, 0, 2, 0, 0, 0, 0));
    vecs.push_back(v(0, ADD,  0, 1, 4'd8,  7'b0000001, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(v(0, LW,   0, 1, 4'd0,  7'b1001100, 2, 0, 2, 0, 0, 0, 0, 1));
    vecs.push_back(v(0, LW,   0, 1, 4'd1,  7'b0000000, 0, 1, 1, 0, 0, 0, 0, 1));
    vecs.push_back(v(0, LW,   0, 1, 4'd2,  7'b0000000, 0, 2, 1, 0, 0, 0, 0, 1));
    vecs.push_back(v(0, LW,   0, 0, 4'd3,  7'b1010000, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(0, LW,   0, 0, 4'd3,  7'b1010000, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(0, LW,   0, 1, 4'd3,  7'b1010000, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(0, LW,   0, 1, 4'd4,  7'b0000001, 1, 0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(v(0, SW,   0, 1, 4'd0,  7'b1001100, 2, 0, 2, 0, 0, 0, 0, 2));
    vecs.push_back(v(0, SW,   0, 1, 4'd1,  7'b0000000, 0, 1, 1, 0, 0, 0, 0, 2));
    vecs.push_back(v(0, SW,   0, 1, 4'd2,  7'b0000000, 0, 2, 1, 0, 0, 0, 0, 2));
    vecs.push_back(v(0, SW,   0, 1, 4'd5,  7'b1110000, 0, 0, 0, 0, 1, 0, 0, 2));
    vecs.push_back(v(0, BEQ,  0, 1, 4'd0,  7'b1001100, 2, 0, 2, 0, 0, 0, 0, 3));
    vecs.push_back(v(0, BEQ,  0, 1, 4'd1,  7'b0000000, 0, 1, 1, 0, 0, 0, 0, 3));
    vecs.push_back(v(0, BEQ,  0, 1, 4'd9,  7'b0000010, 0, 2, 0, 1, 1, 0, 0, 3));
    vecs.push_back(v(0, JALR, 0, 1, 4'd0,  7'b1001100, 2, 0, 2, 0, 0, 0, 0, 4));
    vecs.push_back(v(0, JALR, 0, 1, 4'd1,  7'b0000000, 0, 1, 1, 0, 0, 0, 0, 4));
    vecs.push_back(v(0, JALR, 0, 1, 4'd11, 7'b0000000, 0, 2, 1, 0, 0, 0, 0, 4));
    vecs.push_back(v(0, JALR, 0, 1, 4'd10, 7'b0000100, 0, 1, 2, 0, 0, 0, 0, 4));
    vecs.push_back(v(0, JALR, 0, 1, 4'd8,  7'b0000001, 0, 0, 0, 0, 1, 0, 0, 4));
    vecs.push_back(v(0, ADDI, 1, 1, 4'd0,  7'b1001100, 2, 0, 2, 0, 0, 0, 0, 5));
    vecs.push_back(v(0, ADDI, 1, 1, 4'd1,  7'b0000000, 0, 1, 1, 0, 0, 0, 0, 5));
    vecs.push_back(v(0, ADDI, 1, 1, 4'd7,  7'b0000000, 0, 2, 1, 2, 0, 0, 0, 5));
    vecs.push_back(v(0, ADDI, 1, 1, 4'd8,  7'b0000001, 0, 0, 0, 0, 1, 0, 0, 5));
    vecs.push_back(v(0, LUI,  0, 1, 4'd0,  7'b1001100, 2, 0, 2, 0, 0, 0, 0, 6));
    vecs.push_back(v(0, LUI,  0, 1, 4'd1,  7'b0000000, 0, 1, 1, 0, 0, 0, 0, 6));
    vecs.push_back(v(0, LUI,  0, 1, 4'd12, 7'b0000000, 0, 3, 1, 0, 0, 0, 0, 6));
    vecs.push_back(v(0, LUI,  0, 1, 4'd8,  7'b0000001, 0, 0, 0, 0, 1, 0, 0, 6));
    vecs.push_back(v(0, BEQ,  0, 1, 4'd0,  7'b1001100, 2, 0, 2, 0, 0, 0, 0, 7));
    vecs.push_back(v(0, BEQ,  0, 1, 4'd1,  7'b0000000, 0, 1, 1, 0, 0, 0, 0, 7));
    vecs.push_back(v(0, BEQ,  0, 1, 4'd9,  7'b0000010, 0, 2, 0, 1, 1, 0, 0, 7));
    vecs.push_back(v(0, BAD,  0, 0, 4'd0,  7'b1000000, 2, 0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, BAD,  0, 1, 4'd0,  7'b1001100, 2, 0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, BAD,  0, 1, 4'd1,  7'b0000000, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, BAD,  0, 1, 4'd14, 7'b0000000, 0, 0, 0, 0, 0, 1, 1, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].op, vecs[i].f3, vecs[i].rdy);
      act_w = {6'd0, state_o, mem_req, MemWrite, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, instr_done, fault, fault_cause, instret};
      exp_w = {6'd0, vecs[i].st, vecs[i].en, vecs[i].rs, vecs[i].sa, vecs[i].sb, vecs[i].aop,
               vecs[i].done, vecs[i].flt, vecs[i].cause, vecs[i].ir};
      check($sformatf("vec%0d", i), act_w, exp_w);
    end

    // Fault is sticky and inert for 20 cycles regardless of mem_ready.
    for (int k = 0; k < 20; k++) begin
      drive(0, ADD, 0, k[0]);
      check($sformatf("fault_hold%0d", k),
            {24'd0, state_o, mem_req, RegWrite, fault, fault_cause},
            {24'd0, 4'd14, 1'b0, 1'b0, 1'b1, 2'b01});
    end

    begin
      logic [6:0] ops[10];
      logic [2:0] imm[10];
      ops = '{LW, JALR, ADDI, SW, BEQ, JAL, LUI, AUIP, ADD, BAD};
      imm = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b100, 3'b000, 3'b000};
      for (int k = 0; k < 10; k++) begin
        drive(0, ops[k], 0, 1);
        check($sformatf("immsrc_op%0h", ops[k]), {29'd0, ImmSrc}, {29'd0, imm[k]});
      end
    end

    // One reset cycle clears the trap; then FETCH with no ready times out after 4 wait cycles.
    drive(1, ADD, 0, 0);
    check("rst_in_fault_req", {31'd0, mem_req}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      drive(0, ADD, 0, 0);
      check($sformatf("to_wait%0d", k),
            {24'd0, state_o, mem_req, fault, fault_cause[1], fault_cause[0]},
            {24'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
      if (k == 0) check("post_rst_instret", {29'd0, instret}, 32'd0);
    end
    drive(0, ADD, 0, 0);
    check("timeout_fault",
          {25'd0, state_o, mem_req, fault_cause},
          {25'd0, 4'd14, 1'b0, 2'b10});

    // Reset during a stalled store drops the request that cycle and retires nothing.
    drive(1, SW, 0, 1);
    drive(0, SW, 0, 1);
    drive(0, SW, 0, 1);
    drive(0, SW, 0, 1);
    check("sw_memadr", {28'd0, state_o}, 32'd2);
    drive(0, SW, 0, 0);
    check("sw_wait", {26'd0, state_o, mem_req, MemWrite}, {26'd0, 4'd5, 1'b1, 1'b1});
    drive(1, SW, 0, 0);
    check("sw_rst_cut", {25'd0, state_o, mem_req, MemWrite, instr_done},
          {25'd0, 4'd5, 1'b0, 1'b0, 1'b0});
    drive(0, SW, 0, 0);
    check("sw_rst_after", {25'd0, state_o, instret}, {25'd0, 4'd0, 3'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
